// File: rtl/pc_gen_unit_if.sv
// Fetch request/response bundle between the PC generator and the I-cache.
// master: PC generator side (issues requests, presents responses to decode).
// slave:  I-cache side (accepts requests, signals returned fetches).
interface pc_gen_unit_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic [ADDR_W-1:0] req_pc;
    logic              req_ready;
    logic              rsp_valid;
    logic [ADDR_W-1:0] rsp_pc;
    logic              rsp_stale;

    modport master (
        output req_valid,
        output req_pc,
        output rsp_pc,
        output rsp_stale,
        input  req_ready,
        input  rsp_valid
    );

    modport slave (
        input  req_valid,
        input  req_pc,
        input  rsp_pc,
        input  rsp_stale,
        output req_ready,
        output rsp_valid
    );
endinterface

// File: rtl/pc_gen_unit.sv
// PcGenUnit: fetch-PC generator with an in-order FIFO of outstanding fetches.
// Every outstanding fetch carries the redirect epoch it was issued under, so
// responses that predate the latest redirect come back flagged stale.
// Optional feature macro: PC_GEN_ALIGN_CHECK_EN aligns redirect targets down to
// an instruction boundary and pulses o_misalign_fault for one cycle.
module pc_gen_unit #(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                INST_BYTES = 4,
    parameter int                FIFO_DEPTH = 4,
    parameter int                EPOCH_W    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_stall,
    input  logic              i_redirect_valid,
    input  logic [ADDR_W-1:0] i_redirect_pc,
    pc_gen_unit_if.master     bus,
    output logic              o_underflow_err,
    output logic              o_misalign_fault
);

    localparam int                PTR_W   = $clog2(FIFO_DEPTH);
    localparam int                CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] INC_C   = ADDR_W'(INST_BYTES);

    logic [ADDR_W-1:0]  r_pc;
    logic [EPOCH_W-1:0] r_epoch;
    logic [CNT_W-1:0]   r_count;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [ADDR_W-1:0]  r_fifo_pc    [FIFO_DEPTH];
    logic [EPOCH_W-1:0] r_fifo_epoch [FIFO_DEPTH];
    logic               r_underflow;

    logic               w_full;
    logic               w_req_valid;
    logic               w_fire;
    logic               w_pop;
    logic [ADDR_W-1:0]  w_redirect_pc;

    // The full check uses the registered count only, so a pop cannot refill in the same cycle.
    assign w_full      = (r_count == DEPTH_C);
    assign w_req_valid = !i_stall && !i_redirect_valid && !w_full;
    assign w_fire      = w_req_valid && bus.req_ready;
    assign w_pop       = bus.rsp_valid && (r_count != '0);

    assign bus.req_valid = w_req_valid;
    assign bus.req_pc    = r_pc;
    assign bus.rsp_pc    = r_fifo_pc[r_rd_ptr];
    assign bus.rsp_stale = (r_fifo_epoch[r_rd_ptr] != r_epoch) || i_redirect_valid;

    assign o_underflow_err = r_underflow;

`ifdef PC_GEN_ALIGN_CHECK_EN
    localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'(INST_BYTES - 1);

    logic w_misaligned;
    logic r_misalign;

    assign w_redirect_pc = i_redirect_pc & ~OFFSET_MASK;
    assign w_misaligned  = |(i_redirect_pc & OFFSET_MASK);

    // One-cycle fault pulse following a redirect whose target had offset bits set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= i_redirect_valid && w_misaligned;
        end
    end

    assign o_misalign_fault = r_misalign;
`else
    assign w_redirect_pc    = i_redirect_pc;
    assign o_misalign_fault = 1'b0;
`endif

    // Architectural PC and epoch: a redirect wins over a fire, and stall does not block it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= RESET_PC;
            r_epoch <= '0;
        end else if (i_redirect_valid) begin
            r_pc    <= w_redirect_pc;
            r_epoch <= r_epoch + EPOCH_W'(1);
        end else if (w_fire) begin
            r_pc    <= r_pc + INC_C;
        end
    end

    // Record each accepted request with the epoch it was issued under.
    always_ff @(posedge clk) begin
        if (w_fire) begin
            r_fifo_pc[r_wr_ptr]    <= r_pc;
            r_fifo_epoch[r_wr_ptr] <= r_epoch;
        end
    end

    // FIFO pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_fire) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_fire, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky flag for a response arriving with nothing outstanding; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_underflow <= 1'b0;
        end else if (bus.rsp_valid && (r_count == '0)) begin
            r_underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pc_gen_unit.sv
// Self-checking bench for pc_gen_unit: a table of request-side vectors plus
// hand-written sequences, with a scoreboard queue of outstanding fetches that
// predicts every response PC and stale flag.
module tb_pc_gen_unit;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [1:0]  epoch;
    } sb_t;

    typedef struct {
        logic        stall;
        logic        redirect;
        logic [31:0] redirectPc;
        logic        ready;
        logic        rspValid;
        logic        expValid;
        logic [31:0] expPc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        redirectValid = 1'b0;
    logic [31:0] redirectPc = '0;
    logic        underflowErr;
    logic        misalignFault;

    pc_gen_unit_if #(.ADDR_W(32)) bus ();

    pc_gen_unit dut (
        .clk              (clk),
        .rst              (rst),
        .i_stall          (stall),
        .i_redirect_valid (redirectValid),
        .i_redirect_pc    (redirectPc),
        .bus              (bus),
        .o_underflow_err  (underflowErr),
        .o_misalign_fault (misalignFault)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    sb_t         sb[$];
    logic [31:0] mPc = '0;
    logic [1:0]  mEpoch = '0;
    logic        mUnder = 1'b0;
    logic        mMis = 1'b0;
    logic        tblActive = 1'b0;
    logic        tblValid = 1'b0;
    logic [31:0] tblPc = '0;
    vec_t        vecs[13];

    function automatic vec_t mkVec(logic st, logic rv, logic [31:0] rpc, logic rdy,
                                   logic rsp, logic ev, logic [31:0] epc);
        vec_t v;
        v.stall = st; v.redirect = rv; v.redirectPc = rpc; v.ready = rdy;
        v.rspValid = rsp; v.expValid = ev; v.expPc = epc;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic rv, input logic [31:0] rpc,
                                 input logic rdy, input logic rsp);
        stall         = st;
        redirectValid = rv;
        redirectPc    = rpc;
        bus.req_ready = rdy;
        bus.rsp_valid = rsp;
    endtask

    task automatic resetDut();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        mPc    = 32'h0;
        mEpoch = '0;
        mUnder = 1'b0;
        mMis   = 1'b0;
    endtask

    // Compare outputs mid-cycle against the model, then advance the model across the edge.
    task automatic step();
        logic expValid;
        logic fire;
        logic [31:0] target;
        sb_t head;
        @(negedge clk);
        expValid = !stall && !redirectValid && (sb.size() != DEPTH);
        checkOutput("req_valid", {31'b0, bus.req_valid}, {31'b0, expValid});
        checkOutput("req_pc", bus.req_pc, mPc);
        checkOutput("underflow_err", {31'b0, underflowErr}, {31'b0, mUnder});
        checkOutput("misalign_fault", {31'b0, misalignFault}, {31'b0, mMis});
        if (tblActive) begin
            checkOutput("tbl_req_valid", {31'b0, bus.req_valid}, {31'b0, tblValid});
            checkOutput("tbl_req_pc", bus.req_pc, tblPc);
        end
        fire = expValid && bus.req_ready;
        if (bus.rsp_valid) begin
            if (sb.size() > 0) begin
                head = sb.pop_front();
                checkOutput("rsp_pc", bus.rsp_pc, head.pc);
                checkOutput("rsp_stale", {31'b0, bus.rsp_stale},
                            {31'b0, (head.epoch != mEpoch) || redirectValid});
            end else begin
                mUnder = 1'b1;
            end
        end
        if (fire) begin
            sb.push_back('{pc: mPc, epoch: mEpoch});
        end
`ifdef PC_GEN_ALIGN_CHECK_EN
        target = redirectPc & ~32'h3;
        mMis   = redirectValid && (redirectPc[1:0] != 2'b00);
`else
        target = redirectPc;
        mMis   = 1'b0;
`endif
        if (redirectValid) begin
            foreach (sb[k]) begin
                if (sb[k].epoch == mEpoch + 2'd1) begin
                    errors++;
                    $display("[TB] FAIL epoch_alias: outstanding epoch %0d reused", sb[k].epoch);
                end
            end
            mPc    = target;
            mEpoch = mEpoch + 2'd1;
        end else if (fire) begin
            mPc = mPc + 32'd4;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int n = 0; n < DEPTH + 1 && sb.size() > 0; n++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
            step();
        end
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d entries left, required 0", sb.size());
        end
    endtask

    initial begin
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;

        // Fill to full, drain through the full boundary, then push+pop together.
        vecs[0]  = mkVec(0, 0, 0, 1, 0, 1, 32'h00);
        vecs[1]  = mkVec(0, 0, 0, 1, 0, 1, 32'h04);
        vecs[2]  = mkVec(0, 0, 0, 1, 0, 1, 32'h08);
        vecs[3]  = mkVec(0, 0, 0, 1, 0, 1, 32'h0C);
        vecs[4]  = mkVec(0, 0, 0, 1, 0, 0, 32'h10);
        vecs[5]  = mkVec(0, 0, 0, 1, 1, 0, 32'h10);
        vecs[6]  = mkVec(0, 0, 0, 1, 0, 1, 32'h10);
        vecs[7]  = mkVec(0, 0, 0, 0, 1, 0, 32'h14);
        vecs[8]  = mkVec(0, 0, 0, 0, 1, 1, 32'h14);
        vecs[9]  = mkVec(0, 0, 0, 1, 1, 1, 32'h14);
        vecs[10] = mkVec(0, 0, 0, 0, 1, 1, 32'h18);
        vecs[11] = mkVec(0, 0, 0, 0, 1, 1, 32'h18);
        vecs[12] = mkVec(0, 0, 0, 0, 0, 1, 32'h18);

        resetDut();
        tblActive = 1'b1;
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].stall, vecs[i].redirect, vecs[i].redirectPc,
                          vecs[i].ready, vecs[i].rspValid);
            tblValid = vecs[i].expValid;
            tblPc    = vecs[i].expPc;
            step();
        end
        tblActive = 1'b0;

        // Redirect with two fetches outstanding; older responses come back stale.
        resetDut();
        applyStimulus(0, 0, 32'h0, 1, 0);    step();
        applyStimulus(0, 0, 32'h0, 1, 0);    step();
        applyStimulus(0, 1, 32'h1000, 1, 0); step();
        applyStimulus(0, 0, 32'h0, 0, 1);    step();
        applyStimulus(0, 0, 32'h0, 1, 1);    step();
        applyStimulus(0, 0, 32'h0, 0, 1);    step();
        // Same-cycle redirect marks the popped response stale.
        applyStimulus(0, 0, 32'h0, 1, 0);    step();
        applyStimulus(0, 1, 32'h2000, 0, 1); step();

        // Redirect during stall still loads the PC; requests wait for stall to drop.
        applyStimulus(1, 1, 32'h200, 1, 0);  step();
        applyStimulus(1, 0, 32'h0, 1, 0);    step();
        applyStimulus(1, 0, 32'h0, 1, 0);    step();
        applyStimulus(0, 0, 32'h0, 1, 0);    step();
        drain();

        // PC wraps modulo 2^32.
        applyStimulus(0, 1, 32'hFFFF_FFFC, 0, 0); step();
        applyStimulus(0, 0, 32'h0, 1, 0);         step();
        applyStimulus(0, 0, 32'h0, 0, 0);         step();
        drain();

        // Epoch wraps through several redirects with nothing outstanding.
        for (int r = 0; r < 5; r++) begin
            applyStimulus(0, 1, 32'h3000 + 32'(r) * 32'h10, 0, 0);
            step();
        end
        applyStimulus(0, 0, 32'h0, 1, 0); step();
        drain();

        // Sticky underflow survives traffic; mid-stream reset clears it and the FIFO.
        resetDut();
        applyStimulus(0, 0, 32'h0, 0, 1); step();
        applyStimulus(0, 0, 32'h0, 1, 0); step();
        applyStimulus(0, 0, 32'h0, 1, 1); step();
        applyStimulus(0, 0, 32'h0, 0, 0); step();
        resetDut();
        applyStimulus(0, 0, 32'h0, 0, 0); step();
        applyStimulus(0, 0, 32'h0, 0, 1); step();
        applyStimulus(0, 0, 32'h0, 0, 0); step();

        // Misaligned redirect target.
        applyStimulus(0, 1, 32'h1006, 0, 0); step();
        applyStimulus(0, 0, 32'h0, 1, 0);    step();
        applyStimulus(0, 0, 32'h0, 0, 0);    step();
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
